// File: rtl/fir_mc.sv
// Multi-channel time-multiplexed bit-serial FIR with linear-phase folding.
// One shared coefficient set, per-channel delay lines, valid/ready on both sides.
module fir_mc #(
   parameter int DataWidth  = 12,
   parameter int CoeffWidth = 12,
   parameter int NTaps      = 9,
   parameter int NChannels  = 2,
   localparam int ChanBits  = (NChannels > 1) ? $clog2(NChannels) : 1
) (
   input  logic                        clk,
   input  logic                        rstN,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [ChanBits-1:0]         in_chan,
   input  logic signed [DataWidth-1:0] x,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [ChanBits-1:0]         out_chan,
   output logic signed [DataWidth-1:0] y,
   input  logic                        sym,
   input  logic                        coeff_load,
   input  logic                        coeff_in,
   output logic                        chan_err
);

   localparam int NCoeffs  = (NTaps + 1) / 2;
   localparam int AccWidth = DataWidth + CoeffWidth + $clog2(NTaps) + 1;
   localparam int KBits    = (NCoeffs > 1) ? $clog2(NCoeffs) : 1;
   localparam int BBits    = (DataWidth > 1) ? $clog2(DataWidth) : 1;
   localparam int TBits    = (NTaps > 1) ? $clog2(NTaps) : 1;
   localparam bit OddTaps  = (NTaps % 2) == 1;

   localparam logic [ChanBits:0]               ChanLim = (ChanBits + 1)'(NChannels);
   localparam logic signed [DataWidth-1:0]     YMax    = {1'b0, {(DataWidth-1){1'b1}}};
   localparam logic signed [DataWidth-1:0]     YMin    = {1'b1, {(DataWidth-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, LOAD, MAC, OUT} state_t;

   state_t state, state_n;

   logic [DataWidth-1:0]            line [NChannels][NTaps];
   logic [NCoeffs*CoeffWidth-1:0]   coef_sr;
   logic [ChanBits-1:0]             chan_q;
   logic                            sym_q;
   logic [KBits-1:0]                k_idx;
   logic [BBits-1:0]                b_idx;
   logic signed [AccWidth-1:0]      acc, term, c_ext, acc_sh;
   logic [CoeffWidth-1:0]           c_sel;
   logic [DataWidth-1:0]            tap_a, tap_b;
   logic [TBits-1:0]                tap_idx, mirror;
   logic                            bit_a, bit_b, mid, mac_last;
   logic                            accept, chan_bad, coef_shift;
   logic signed [DataWidth-1:0]     y_sat;

   assign chan_bad = {1'b0, in_chan} >= ChanLim;

   always_comb begin
      state_n    = state;
      in_ready   = 1'b0;
      accept     = 1'b0;
      coef_shift = 1'b0;
      case (state)
         IDLE: begin
            in_ready   = !coeff_load;
            accept     = in_valid && !coeff_load;
            coef_shift = coeff_load;
            if (coeff_load)
               state_n = LOAD;
            else if (in_valid && !chan_bad)
               state_n = MAC;
         end
         LOAD: begin
            coef_shift = coeff_load;
            if (!coeff_load)
               state_n = IDLE;
         end
         MAC: begin
            if (mac_last)
               state_n = OUT;
         end
         OUT: begin
            if (out_valid && out_ready)
               state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   // Taps are read by index rather than by rotating the line, so each line
   // is never disturbed during a computation.
   always_comb begin
      c_sel = '0;
      tap_a = '0;
      tap_b = '0;
      for (int unsigned k = 0; k < NCoeffs; k++)
         if (k_idx == KBits'(k))
            c_sel = coef_sr[k*CoeffWidth +: CoeffWidth];
      tap_idx = TBits'(k_idx);
      mirror  = TBits'(NTaps - 1) - tap_idx;
      for (int unsigned ch = 0; ch < NChannels; ch++)
         if (chan_q == ChanBits'(ch)) begin
            tap_a = line[ch][tap_idx];
            tap_b = line[ch][mirror];
         end
      mid   = OddTaps && (k_idx == KBits'(NCoeffs - 1));
      bit_a = tap_a[b_idx];
      bit_b = mid ? 1'b0 : tap_b[b_idx];
      c_ext = AccWidth'($signed(c_sel));
      term  = '0;
      if (sym_q) begin
         case ({bit_a, bit_b})
            2'b01, 2'b10: term = c_ext;
            2'b11:        term = c_ext <<< 1;
            default:      term = '0;
         endcase
      end else begin
         case ({bit_a, bit_b})
            2'b10:   term = c_ext;
            2'b01:   term = -c_ext;
            default: term = '0;
         endcase
      end
      term = term <<< b_idx;
      // sign bit of the two's-complement pre-add digit carries negative weight
      if (b_idx == BBits'(DataWidth - 1))
         term = -term;
      mac_last = (k_idx == KBits'(NCoeffs - 1)) && (b_idx == BBits'(DataWidth - 1));
      acc_sh   = acc >>> (CoeffWidth - 1);
      if (acc_sh > AccWidth'(YMax))
         y_sat = YMax;
      else if (acc_sh < AccWidth'(YMin))
         y_sat = YMin;
      else
         y_sat = acc_sh[DataWidth-1:0];
   end

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         state <= IDLE;
         for (int unsigned ch = 0; ch < NChannels; ch++)
            for (int unsigned t = 0; t < NTaps; t++)
               line[ch][t] <= '0;
         coef_sr   <= '0;
         chan_q    <= '0;
         sym_q     <= 1'b0;
         k_idx     <= '0;
         b_idx     <= '0;
         acc       <= '0;
         y         <= '0;
         out_chan  <= '0;
         out_valid <= 1'b0;
         chan_err  <= 1'b0;
      end else begin
         state <= state_n;
         if (coef_shift)
            coef_sr <= {coef_sr[NCoeffs*CoeffWidth-2:0], coeff_in};
         if (accept) begin
            if (chan_bad) begin
               chan_err <= 1'b1;
            end else begin
               for (int unsigned ch = 0; ch < NChannels; ch++)
                  if (in_chan == ChanBits'(ch)) begin
                     line[ch][0] <= x;
                     for (int unsigned t = 1; t < NTaps; t++)
                        line[ch][t] <= line[ch][t-1];
                  end
               chan_q <= in_chan;
               sym_q  <= sym;
               acc    <= '0;
               k_idx  <= '0;
               b_idx  <= '0;
            end
         end
         if (state == MAC) begin
            acc <= acc + term;
            if (b_idx == BBits'(DataWidth - 1)) begin
               b_idx <= '0;
               k_idx <= k_idx + 1'b1;
            end else begin
               b_idx <= b_idx + 1'b1;
            end
         end
         if (state == OUT) begin
            if (!out_valid) begin
               out_valid <= 1'b1;
               y         <= y_sat;
               out_chan  <= chan_q;
            end else if (out_ready) begin
               out_valid <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_fir_mc.sv
// Scoreboard bench for fir_mc: expected outputs queued at sample accept,
// compared when the DUT hands a result over.
module tb_fir_mc;
   localparam int DW = 12;
   localparam int CW = 12;
   localparam int NT = 9;
   localparam int NC = 5;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rstN, in_valid, in_ready, in_chan, out_valid, out_ready, out_chan;
   logic sym, coeff_load, coeff_in, chan_err;
   logic signed [DW-1:0] x, y;

   logic in_valid3, in_ready3, out_valid3, chan_err3;
   logic [1:0] in_chan3, out_chan3;
   logic signed [DW-1:0] y3;

   fir_mc #(.DataWidth(DW), .CoeffWidth(CW), .NTaps(NT), .NChannels(2)) u_dut (
      .clk(clk), .rstN(rstN), .in_valid(in_valid), .in_ready(in_ready), .in_chan(in_chan),
      .x(x), .out_valid(out_valid), .out_ready(out_ready), .out_chan(out_chan), .y(y),
      .sym(sym), .coeff_load(coeff_load), .coeff_in(coeff_in), .chan_err(chan_err));

   fir_mc #(.DataWidth(DW), .CoeffWidth(CW), .NTaps(NT), .NChannels(3)) u_dut3 (
      .clk(clk), .rstN(rstN), .in_valid(in_valid3), .in_ready(in_ready3), .in_chan(in_chan3),
      .x(12'sd0), .out_valid(out_valid3), .out_ready(1'b1), .out_chan(out_chan3), .y(y3),
      .sym(1'b1), .coeff_load(1'b0), .coeff_in(1'b0), .chan_err(chan_err3));

   typedef struct { int ch; int y; } exp_t;
   exp_t q[$];

   int n_checks = 0;
   int n_errors = 0;
   int mc[NC];
   int ml[2][NT];
   int cset[NC];
   int imp_sym[10]  = '{500, 0, 0, 0, 0, 0, 0, 0, 500, 0};
   int imp_anti[10] = '{500, 0, 0, 0, 0, 0, 0, 0, -500, 0};
   int last_y = 0;

   task automatic check(input string tag, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   function automatic int model_y(input int ch, input bit s);
      longint acc = 0;
      for (int k = 0; k < NC; k++) begin
         if (k == NC - 1 && (NT % 2) == 1)
            acc += longint'(mc[k]) * ml[ch][k];
         else if (s)
            acc += longint'(mc[k]) * (ml[ch][k] + ml[ch][NT-1-k]);
         else
            acc += longint'(mc[k]) * (ml[ch][k] - ml[ch][NT-1-k]);
      end
      acc = acc >>> (CW - 1);
      if (acc > 2047) acc = 2047;
      if (acc < -2048) acc = -2048;
      return int'(acc);
   endfunction

   // mode 0: no output expected, 1: model value, 2: given value
   task automatic send(input int ch, input int val, input bit s, input int mode, input int expv);
      int n = 0;
      logic [31:0] v;
      while (!in_ready && n < 300) begin
         @(posedge clk); #1;
         n++;
      end
      if (!in_ready) begin
         check("in_ready_wait", 0, 1);
         return;
      end
      v = val;
      in_valid = 1'b1;
      in_chan  = ch[0];
      x        = v[DW-1:0];
      sym      = s;
      @(posedge clk); #1;
      in_valid = 1'b0;
      for (int t = NT - 1; t > 0; t--)
         ml[ch][t] = ml[ch][t-1];
      ml[ch][0] = val;
      if (mode == 1)
         q.push_back('{ch, model_y(ch, s)});
      else if (mode == 2)
         q.push_back('{ch, expv});
   endtask

   task automatic load_coeffs();
      logic [31:0] w;
      for (int k = NC - 1; k >= 0; k--) begin
         w = cset[k];
         for (int b = CW - 1; b >= 0; b--) begin
            coeff_load = 1'b1;
            coeff_in   = w[b];
            @(posedge clk); #1;
         end
      end
      coeff_load = 1'b0;
      coeff_in   = 1'b0;
      for (int k = 0; k < NC; k++)
         mc[k] = (cset[k] >= 2048) ? cset[k] - 4096 : cset[k];
      @(posedge clk); #1;
   endtask

   task automatic wait_drain();
      int n = 0;
      while ((q.size() != 0 || !in_ready) && n < 500) begin
         @(posedge clk); #1;
         n++;
      end
      if (q.size() != 0 || !in_ready)
         check("drain_timeout", q.size(), 0);
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (rstN === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
         if (q.size() == 0) begin
            check("unexpected_out", 1, 0);
         end else begin
            e = q.pop_front();
            check("y", int'(y), e.y);
            check("out_chan", int'(out_chan), e.ch);
            last_y = int'(y);
         end
      end
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, bad_y, bad_rdy, nv;
      logic signed [DW-1:0] y0;
      rstN = 1'b0; in_valid = 1'b0; in_chan = 1'b0; x = '0; out_ready = 1'b1;
      sym = 1'b1; coeff_load = 1'b0; coeff_in = 1'b0;
      in_valid3 = 1'b0; in_chan3 = '0;
      for (int c = 0; c < 2; c++) for (int t = 0; t < NT; t++) ml[c][t] = 0;
      for (int k = 0; k < NC; k++) mc[k] = 0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_out_valid", out_valid, 0);
      check("rst_y", int'(y), 0);
      check("rst_out_chan", out_chan, 0);
      check("rst_chan_err", chan_err, 0);
      check("rst_in_ready", in_ready, 1);
      rstN = 1'b1;
      @(posedge clk); #1;

      // symmetric impulse
      cset = '{'h400, 0, 0, 0, 0};
      load_coeffs();
      for (int i = 0; i < 10; i++) send(0, (i == 0) ? 1000 : 0, 1'b1, 2, imp_sym[i]);
      wait_drain();

      // antisymmetric impulse
      for (int i = 0; i < 10; i++) send(0, (i == 0) ? 1000 : 0, 1'b0, 2, imp_anti[i]);
      wait_drain();

      // saturation both ways
      cset = '{'h7FF, 'h7FF, 'h7FF, 'h7FF, 'h7FF};
      load_coeffs();
      for (int i = 0; i < 10; i++) send(0, 2047, 1'b1, 1, 0);
      wait_drain();
      check("sat_pos", last_y, 2047);
      for (int i = 0; i < 10; i++) send(0, -2048, 1'b1, 1, 0);
      wait_drain();
      check("sat_neg", last_y, -2048);

      // channel independence
      cset = '{'h400, 0, 0, 0, 0};
      load_coeffs();
      for (int i = 0; i < 9; i++) send(0, 0, 1'b1, 1, 0);
      wait_drain();
      for (int i = 0; i < 10; i++) begin
         send(1, (i == 0) ? 1000 : 0, 1'b1, 2, imp_sym[i]);
         send(0, 0, 1'b1, 2, 0);
      end
      wait_drain();

      // out-of-range channel on the three-channel instance
      check("chan_err3_pre", chan_err3, 0);
      in_valid3 = 1'b1;
      in_chan3  = 2'd3;
      check("chan_err3_ready", in_ready3, 1);
      @(posedge clk); #1;
      in_valid3 = 1'b0;
      check("chan_err3_set", chan_err3, 1);
      nv = 0;
      repeat (70) begin
         @(posedge clk); #1;
         if (out_valid3) nv++;
      end
      check("chan_err3_no_out", nv, 0);
      check("chan_err3_idle", in_ready3, 1);
      check("chan_err3_y", int'(y3), 0);
      check("chan_err3_out_chan", int'(out_chan3), 0);

      // latency and output hold under backpressure
      out_ready = 1'b0;
      send(0, 300, 1'b1, 1, 0);
      n = 0;
      while (!out_valid && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      check("latency", n, 61);
      y0 = y;
      bad_y = 0;
      bad_rdy = 0;
      repeat (10) begin
         @(posedge clk); #1;
         if (y !== y0) bad_y++;
         if (in_ready) bad_rdy++;
      end
      check("hold_y", bad_y, 0);
      check("hold_in_ready", bad_rdy, 0);
      check("hold_valid", out_valid, 1);
      out_ready = 1'b1;
      wait_drain();

      // coefficient load attempts during MAC are ignored
      cset = '{'h123, 'h7FF, 'h800, 'h055, 'hA00};
      load_coeffs();
      send(0, 700, 1'b0, 1, 0);
      bad_rdy = 0;
      repeat (20) begin
         coeff_load = 1'b1;
         coeff_in   = 1'($urandom_range(0, 1));
         @(posedge clk); #1;
         if (in_ready) bad_rdy++;
      end
      coeff_load = 1'b0;
      check("mac_in_ready", bad_rdy, 0);
      wait_drain();
      for (int i = 0; i < 12; i++)
         send(i % 2, int'($urandom_range(0, 4095)) - 2048, 1'(i / 2 % 2), 1, 0);
      wait_drain();

      // reset in the middle of a computation
      send(0, 1234, 1'b1, 0, 0);
      repeat (20) @(posedge clk);
      #1;
      rstN = 1'b0;
      #1;
      check("midrst_out_valid", out_valid, 0);
      check("midrst_y", int'(y), 0);
      check("midrst_in_ready", in_ready, 1);
      for (int c = 0; c < 2; c++) for (int t = 0; t < NT; t++) ml[c][t] = 0;
      for (int k = 0; k < NC; k++) mc[k] = 0;
      @(posedge clk); #1;
      rstN = 1'b1;
      @(posedge clk); #1;
      check("postrst_in_ready", in_ready, 1);
      cset = '{'h400, 0, 0, 0, 0};
      load_coeffs();
      for (int i = 0; i < 10; i++) send(0, (i == 0) ? 1000 : 0, 1'b1, 2, imp_sym[i]);
      wait_drain();
      check("final_chan_err", chan_err, 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
